// File: rtl/gcn_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : gcn_pkg                                                      |
// | Description : Shared widths, FSM state type and row type for the          |
// |               FM_WM_ADJ aggregation block.                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package gcn_pkg;

  localparam int DOT_PROD_WIDTH = 16;  // element width of FM_WM / FM_WM_ADJ
  localparam int FM_WM_COLS     = 3;   // columns per row (output classes)
  localparam int FM_WM_ROWS     = 6;   // FM_WM rows == adjacency row width
  localparam int FEATURE_ROWS   = 6;   // output rows (nodes)

  localparam int FM_WM_WIDTH = $clog2(FM_WM_ROWS);
  localparam int COUNT_WIDTH = $clog2(FEATURE_ROWS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } agg_state_t;

  // Element [c] is column c; column 0 occupies the least significant bits.
  typedef logic [FM_WM_COLS-1:0][DOT_PROD_WIDTH-1:0] fm_row_t;

endpackage : gcn_pkg
`default_nettype wire

// File: rtl/fm_wm_adj_row_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fm_wm_adj_row_buffer                                         |
// | Description : Row store for FM_WM_ADJ. Synchronous write, combinational    |
// |               read, out-of-range read addresses return zero, whole store   |
// |               cleared synchronously on reset.                              |
// | Ports       : clk, reset        - clock / sync active-high reset           |
// |               we, waddr, wdata  - row write port                           |
// |               raddr, rdata      - combinational row read port              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fm_wm_adj_row_buffer
  import gcn_pkg::*;
#(
  parameter int DEPTH   = FEATURE_ROWS,
  parameter int WADDR_W = COUNT_WIDTH,
  parameter int RADDR_W = FM_WM_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [WADDR_W-1:0] waddr,
  input  fm_row_t            wdata,
  input  logic [RADDR_W-1:0] raddr,
  output fm_row_t            rdata
);

  // One extra bit so DEPTH itself is representable in the range compare.
  localparam logic [RADDR_W:0] c_DEPTH = (RADDR_W+1)'(DEPTH);

  fm_row_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = ({1'b0, raddr} < c_DEPTH) ? r_mem[raddr] : '0;

endmodule : fm_wm_adj_row_buffer
`default_nettype wire

// File: rtl/fm_wm_adj_aggregator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fm_wm_adj_aggregator                                         |
// | Description : Computes FM_WM_ADJ = ADJ x FM_WM one output row at a time.   |
// |               For output row r, walks k over all FM_WM rows, adding row k  |
// |               into the accumulators when adjacency bit k of row r is set,  |
// |               then writes the finished row into the row buffer.            |
// | Ports       : clk, reset      - clock / sync active-high reset             |
// |               start           - level, begins a run from IDLE              |
// |               fm_wm_row       - FM_WM read address (k)                     |
// |               fm_wm_row_data  - FM_WM row at fm_wm_row (comb.)             |
// |               adj_row         - adjacency read address (r)                 |
// |               adj_row_bits    - adjacency row at adj_row (comb.)           |
// |               fm_wm_adj_row   - buffer read address (argmax stage)         |
// |               fm_wm_adj_out   - buffered row at fm_wm_adj_row (comb.)      |
// |               done            - high while all rows are valid              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fm_wm_adj_aggregator
  import gcn_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic [FM_WM_WIDTH-1:0] fm_wm_row,
  input  fm_row_t                fm_wm_row_data,
  output logic [COUNT_WIDTH-1:0] adj_row,
  input  logic [FM_WM_ROWS-1:0]  adj_row_bits,
  input  logic [FM_WM_WIDTH-1:0] fm_wm_adj_row,
  output fm_row_t                fm_wm_adj_out,
  output logic                   done
);

  localparam logic [FM_WM_WIDTH-1:0] c_K_LAST = FM_WM_WIDTH'(FM_WM_ROWS - 1);
  localparam logic [COUNT_WIDTH-1:0] c_R_LAST = COUNT_WIDTH'(FEATURE_ROWS - 1);

  agg_state_t             r_state, w_state_next;
  logic [FM_WM_WIDTH-1:0] r_k, w_k_next;
  logic [COUNT_WIDTH-1:0] r_r, w_r_next;
  fm_row_t                r_acc, w_acc_next;
  logic                   r_done, w_done_next;
  logic                   w_we;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_r     <= '0;
      r_acc   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_k     <= w_k_next;
      r_r     <= w_r_next;
      r_acc   <= w_acc_next;
      r_done  <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_k_next     = r_k;
    w_r_next     = r_r;
    w_acc_next   = r_acc;
    w_done_next  = r_done;
    w_we         = 1'b0;
    fm_wm_row    = '0;
    adj_row      = '0;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = ACCUM;
          w_k_next     = '0;
          w_r_next     = '0;
          w_acc_next   = '0;
          w_done_next  = 1'b0;
        end
      end

      ACCUM: begin
        fm_wm_row = r_k;
        adj_row   = r_r;
        // Sums wrap naturally at DOT_PROD_WIDTH bits.
        for (int c = 0; c < FM_WM_COLS; c++) begin
          w_acc_next[c] = r_acc[c] + (adj_row_bits[r_k] ? fm_wm_row_data[c]
                                                        : '0);
        end
        if (r_k == c_K_LAST) begin
          w_state_next = WRITE;
          w_k_next     = '0;
        end else begin
          w_k_next = r_k + 1'b1;
        end
      end

      WRITE: begin
        w_we       = 1'b1;
        w_acc_next = '0;
        if (r_r == c_R_LAST) begin
          w_state_next = DONE;
          w_done_next  = 1'b1;
        end else begin
          w_r_next     = r_r + 1'b1;
          w_state_next = ACCUM;
        end
      end

      DONE: begin
        // Holding start high parks here; a new run needs a low-then-high start.
        w_done_next = 1'b1;
        if (!start) begin
          w_state_next = IDLE;
          w_done_next  = 1'b0;
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign done = r_done;

  fm_wm_adj_row_buffer #(
    .DEPTH   (FEATURE_ROWS),
    .WADDR_W (COUNT_WIDTH),
    .RADDR_W (FM_WM_WIDTH)
  ) u_row_buffer (
    .clk   (clk),
    .reset (reset),
    .we    (w_we),
    .waddr (r_r),
    .wdata (r_acc),
    .raddr (fm_wm_adj_row),
    .rdata (fm_wm_adj_out)
  );

endmodule : fm_wm_adj_aggregator
`default_nettype wire

// File: tb/tb_fm_wm_adj_aggregator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fm_wm_adj_aggregator                                      |
// | Description : Self-checking bench for fm_wm_adj_aggregator. A timeline     |
// |               model computes matrix rows directly from the stored ADJ and  |
// |               FM_WM contents; literal checks pin the model.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fm_wm_adj_aggregator;
  import gcn_pkg::*;

  localparam int RUN_EDGES = FEATURE_ROWS * (FM_WM_ROWS + 1);

  logic                   clk;
  logic                   reset;
  logic                   start;
  logic [FM_WM_WIDTH-1:0] fm_wm_row;
  fm_row_t                fm_wm_row_data;
  logic [COUNT_WIDTH-1:0] adj_row;
  logic [FM_WM_ROWS-1:0]  adj_row_bits;
  logic [FM_WM_WIDTH-1:0] fm_wm_adj_row;
  fm_row_t                fm_wm_adj_out;
  logic                   done;

  int checks = 0;
  int errors = 0;

  // Stimulus memories served combinationally to the DUT.
  fm_row_t               fm_mem  [FM_WM_ROWS];
  logic [FM_WM_ROWS-1:0] adj_mem [FEATURE_ROWS];

  fm_wm_adj_aggregator dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .fm_wm_row      (fm_wm_row),
    .fm_wm_row_data (fm_wm_row_data),
    .adj_row        (adj_row),
    .adj_row_bits   (adj_row_bits),
    .fm_wm_adj_row  (fm_wm_adj_row),
    .fm_wm_adj_out  (fm_wm_adj_out),
    .done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    fm_wm_row_data = (int'(fm_wm_row) < FM_WM_ROWS) ? fm_mem[fm_wm_row] : '0;
    adj_row_bits   = (int'(adj_row) < FEATURE_ROWS) ? adj_mem[adj_row] : '0;
  end

  function automatic fm_row_t mk(input int a, input int b, input int c);
    fm_row_t v;
    v[0] = DOT_PROD_WIDTH'(a);
    v[1] = DOT_PROD_WIDTH'(b);
    v[2] = DOT_PROD_WIDTH'(c);
    return v;
  endfunction

  // Row r of ADJ x FM_WM, straight from the definition of a matrix product.
  function automatic fm_row_t exp_row(input int r);
    fm_row_t v;
    for (int c = 0; c < FM_WM_COLS; c++) begin
      longint unsigned s = 0;
      for (int k = 0; k < FM_WM_ROWS; k++)
        if (adj_mem[r][k]) s += longint'(fm_mem[k][c]);
      v[c] = s[DOT_PROD_WIDTH-1:0];
    end
    return v;
  endfunction

  // ---------------- timeline model ----------------
  // mode 0 idle, 1 running, 2 finished. Row r lands at edge 7(r+1) of a run.
  int      m_mode  = 0;
  int      m_cnt   = 0;
  bit      m_done  = 0;
  bit      m_valid = 0;
  fm_row_t m_buf [FEATURE_ROWS];

  always @(posedge clk) begin
    if (reset) begin
      m_mode = 0; m_cnt = 0; m_done = 0; m_valid = 1;
      for (int i = 0; i < FEATURE_ROWS; i++) m_buf[i] = '0;
    end else if (m_mode == 0) begin
      if (start) begin m_mode = 1; m_cnt = 0; end
    end else if (m_mode == 1) begin
      m_cnt++;
      if (m_cnt % (FM_WM_ROWS + 1) == 0)
        m_buf[m_cnt / (FM_WM_ROWS + 1) - 1] = exp_row(m_cnt / (FM_WM_ROWS + 1) - 1);
      if (m_cnt == RUN_EDGES) begin m_mode = 2; m_done = 1; end
    end else begin
      if (!start) begin m_mode = 0; m_done = 0; end
    end
  end

  function automatic fm_row_t model_read(input logic [FM_WM_WIDTH-1:0] a);
    return (int'(a) < FEATURE_ROWS) ? m_buf[a] : '0;
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      checks++;
      if (done !== m_done) begin
        errors++;
        $display("FAIL model_done t=%0t got=%0b exp=%0b", $time, done, m_done);
      end
      checks++;
      if (fm_wm_adj_out !== model_read(fm_wm_adj_row)) begin
        errors++;
        $display("FAIL model_read t=%0t addr=%0d got=%h exp=%h", $time,
                 fm_wm_adj_row, fm_wm_adj_out, model_read(fm_wm_adj_row));
      end
      if (m_mode != 1) begin
        checks++;
        if (fm_wm_row !== '0 || adj_row !== '0) begin
          errors++;
          $display("FAIL idle_addr t=%0t fm_wm_row=%0d adj_row=%0d exp=0", $time,
                   fm_wm_row, adj_row);
        end
      end
    end
  end

  // ---------------- literal checks ----------------
  task automatic check_row(input string name, input int a, input fm_row_t exp);
    @(posedge clk); #2 fm_wm_adj_row = FM_WM_WIDTH'(a); #1;
    checks++;
    if (fm_wm_adj_out !== exp) begin
      errors++;
      $display("FAIL %s addr=%0d got=%h exp=%h", name, a, fm_wm_adj_out, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0b exp=%0b", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic sweep_reads();
    for (int a = 0; a < 8; a++) begin
      @(posedge clk); #2 fm_wm_adj_row = FM_WM_WIDTH'(a);
    end
  endtask

  // Starts a run and returns the number of edges from the start-sampling edge
  // to the first edge after which done is observed high (-1 if never).
  task automatic do_run(input bit hold, input bit pulse, output int lat);
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2;
    if (!hold) start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (done) begin lat = n; break; end
      #1;
      if (pulse && n == 15) start = 1'b1;   // sampled at edge 16: ACCUM of row 2
      if (pulse && n == 16) start = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    reset = 1'b1; start = 1'b0; fm_wm_adj_row = '0;
    for (int k = 0; k < FM_WM_ROWS; k++) fm_mem[k] = '0;
    for (int r = 0; r < FEATURE_ROWS; r++) adj_mem[r] = '0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0; #1;
    check_bit("reset_done", done, 1'b0);
    check_row("reset_row0", 0, mk(0, 0, 0));

    // Identity adjacency, FM_WM[k] = {k, 2k, 3k}.
    for (int k = 0; k < FM_WM_ROWS; k++) fm_mem[k] = mk(k, 2 * k, 3 * k);
    for (int r = 0; r < FEATURE_ROWS; r++) adj_mem[r] = FM_WM_ROWS'(1 << r);
    do_run(1'b0, 1'b0, lat);
    check_int("identity_latency", lat, 42);
    check_row("identity_row4", 4, mk(4, 8, 12));
    check_row("identity_row5", 5, mk(5, 10, 15));
    sweep_reads();

    // All-ones adjacency, every FM_WM row {1,2,3}.
    for (int k = 0; k < FM_WM_ROWS; k++) fm_mem[k] = mk(1, 2, 3);
    for (int r = 0; r < FEATURE_ROWS; r++) adj_mem[r] = '1;
    do_run(1'b0, 1'b0, lat);
    check_int("allones_latency", lat, 42);
    for (int a = 0; a < FEATURE_ROWS; a++) check_row("allones_row", a, mk(6, 12, 18));

    // Wrap-around.
    for (int k = 0; k < FM_WM_ROWS; k++) fm_mem[k] = '0;
    for (int r = 0; r < FEATURE_ROWS; r++) adj_mem[r] = '0;
    fm_mem[0] = mk(16'hFFFF, 16'h8000, 1);
    fm_mem[1] = mk(16'hFFFF, 16'h8000, 1);
    adj_mem[0] = 6'b000011;
    do_run(1'b0, 1'b0, lat);
    check_row("wrap_row0", 0, mk(16'hFFFE, 0, 2));
    check_row("wrap_row1", 1, mk(0, 0, 0));

    // Reset at edge 20 of an identity run, then an all-zero-adjacency run.
    for (int k = 0; k < FM_WM_ROWS; k++) fm_mem[k] = mk(k + 1, 2 * k + 1, 3 * k + 1);
    for (int r = 0; r < FEATURE_ROWS; r++) adj_mem[r] = FM_WM_ROWS'(1 << r);
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    repeat (19) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #2 reset = 1'b0; #1;
    check_bit("midrun_reset_done", done, 1'b0);
    check_row("midrun_reset_row0", 0, mk(0, 0, 0));
    sweep_reads();
    for (int r = 0; r < FEATURE_ROWS; r++) adj_mem[r] = '0;
    do_run(1'b0, 1'b0, lat);
    check_int("zeroadj_latency", lat, 42);
    for (int a = 0; a < FEATURE_ROWS; a++) check_row("zeroadj_row", a, mk(0, 0, 0));

    // start held high through DONE.
    for (int k = 0; k < FM_WM_ROWS; k++) fm_mem[k] = mk(k, 2 * k, 3 * k);
    for (int r = 0; r < FEATURE_ROWS; r++) adj_mem[r] = FM_WM_ROWS'(1 << r);
    do_run(1'b1, 1'b0, lat);
    check_int("hold_latency", lat, 42);
    repeat (50) @(posedge clk);
    #1 check_bit("hold_done_stays", done, 1'b1);
    #1 start = 1'b0;
    @(posedge clk); #1;
    check_bit("hold_release_done", done, 1'b0);
    check_row("hold_row3", 3, mk(3, 6, 9));
    check_row("hold_row6", 6, mk(0, 0, 0));
    check_row("hold_row7", 7, mk(0, 0, 0));

    // start pulsed during ACCUM of row 2.
    for (int k = 0; k < FM_WM_ROWS; k++) fm_mem[k] = mk(7 * k + 1, k, 100);
    for (int r = 0; r < FEATURE_ROWS; r++) adj_mem[r] = FM_WM_ROWS'(6'b100101 >> (r % 3));
    do_run(1'b0, 1'b1, lat);
    check_int("pulse_latency", lat, 42);
    sweep_reads();
    check_row("pulse_row0", 0, mk(1 + 15 + 36, 0 + 2 + 5, 300));

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fm_wm_adj_aggregator
`default_nettype wire
